// File: rtl/elevator_top.sv
// -----------------------------------------------------------------------------
// elevator_top : three-floor elevator controller (single CLK_50 clock domain)
//
// A free-running divider turns CLK_50 into a slow square wave (clk, exported
// for observation only) and a one-cycle tick that paces the service FSM.
// The FSM serves floor calls, times the door, honours the weight sensor and
// toggles an SOS emergency mode that takes effect immediately (not on a tick).
//
// Ports:
//   CLK_50            in   system clock
//   reset             in   synchronous, active-high reset
//   clk               out  divided square wave, period clk_frequency cycles
//   sos_button        in   SOS push button (rising edge toggles emergency)
//   weight_sensor     in   1 = cabin overloaded
//   st/nd/rd_floor_button in  floor 1/2/3 call buttons
//   sos_led           out  1 while in EMERGENCY
//   weight_led        out  registered copy of weight_sensor
//   emergency_led     out  sos_led AND clk (blinks at divided rate)
//   st/nd/rd_floor_led out one-hot cabin position
//   door_status_led   out  1 = door open
//
// Optional feature macro: ELEVATOR_HOME_RETURN_EN
//   When defined, after 10 consecutive idle ticks with no requests away from
//   floor 1, a floor-1 request is inserted so the cabin parks at floor 1.
// -----------------------------------------------------------------------------
module elevator_top #(
  parameter int clk_frequency = 50000000,
  parameter int DOOR_TICKS    = 3
) (
  input  logic CLK_50,
  input  logic reset,
  output logic clk,
  input  logic sos_button,
  input  logic weight_sensor,
  input  logic st_floor_button,
  input  logic nd_floor_button,
  input  logic rd_floor_button,
  output logic sos_led,
  output logic weight_led,
  output logic emergency_led,
  output logic st_floor_led,
  output logic nd_floor_led,
  output logic rd_floor_led,
  output logic door_status_led
);

  localparam int CW = (clk_frequency > 2) ? $clog2(clk_frequency) : 1;
  localparam int TW = $clog2(DOOR_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(clk_frequency - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(clk_frequency / 2);
  localparam logic [TW-1:0] T_LOAD   = TW'(DOOR_TICKS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2,
    EMERGENCY = 2'd3
  } state_t;

  // One step of the one-hot floor position; callers only step when a request
  // exists in that direction, so the cabin never leaves floors 1..3.
  function automatic logic [2:0] step_floor(input logic [2:0] f, input logic up);
    return up ? (f << 1) : (f >> 1);
  endfunction

  // ---------------- divider ----------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q;
  logic          tick;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // ---------------- control state ----------------
  state_t        state_q, state_d;
  logic [2:0]    floor_q, floor_d;   // one-hot, bit0 = floor 1
  logic [2:0]    req_q, req_d;       // bit0 = floor 1
  logic          dir_q, dir_d;       // 1 = up
  logic [TW-1:0] timer_q, timer_d;
  logic          sos_prev_q;
  logic          weight_q;

  logic [2:0] btn;
  logic       sos_rise;
  logic       here_req, up_req, dn_req, fwd_req, rev_req;
  logic       btn_here_open;
  logic       go_up;

  always_comb begin
    btn      = {rd_floor_button, nd_floor_button, st_floor_button};
    sos_rise = sos_button & ~sos_prev_q;
    here_req = |(req_q & floor_q);
    // Requests strictly above / below the current floor.
    up_req   = |(req_q & {floor_q[1] | floor_q[0], floor_q[0], 1'b0});
    dn_req   = |(req_q & {1'b0, floor_q[2], floor_q[2] | floor_q[1]});
    fwd_req  = dir_q ? up_req : dn_req;
    rev_req  = dir_q ? dn_req : up_req;
    // Pressing the button of the floor whose door is open holds the door.
    btn_here_open = (state_q == DOOR_OPEN) && |(btn & floor_q);
  end

`ifdef ELEVATOR_HOME_RETURN_EN
  logic [3:0] home_cnt_q, home_cnt_d;
  logic       home_cond;
  assign home_cond = (state_q == IDLE) && (req_q == 3'b000) && !floor_q[0];
`endif

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    go_up   = 1'b0;
    // The open floor's own button never becomes a pending request.
    req_d   = req_q | (btn & ((state_q == DOOR_OPEN) ? ~floor_q : 3'b111));
    if (btn_here_open) timer_d = T_LOAD;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (here_req) begin
            req_d   = req_d & ~floor_q;
            state_d = DOOR_OPEN;
            timer_d = T_LOAD;
          end else if ((up_req || dn_req) && !weight_q) begin
            // Keep heading the same way if there is work there, otherwise
            // take whichever side has a request.
            go_up   = fwd_req ? dir_q : up_req;
            dir_d   = go_up;
            floor_d = step_floor(floor_q, go_up);
            state_d = MOVING;
          end
        end
        MOVING: begin
          if (here_req) begin
            req_d   = req_d & ~floor_q;
            state_d = DOOR_OPEN;
            timer_d = T_LOAD;
          end else if (fwd_req) begin
            floor_d = step_floor(floor_q, dir_q);
          end else if (rev_req) begin
            dir_d   = ~dir_q;
            floor_d = step_floor(floor_q, ~dir_q);
          end else begin
            state_d = IDLE;
          end
        end
        DOOR_OPEN: begin
          if (weight_q || btn_here_open) begin
            timer_d = T_LOAD;
          end else if (timer_q <= TW'(1)) begin
            // Closing on the tick that would take the count to zero gives
            // exactly DOOR_TICKS ticks of open door.
            timer_d = '0;
            state_d = IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: ;
      endcase
    end

`ifdef ELEVATOR_HOME_RETURN_EN
    home_cnt_d = home_cnt_q;
    if (!home_cond) begin
      home_cnt_d = '0;
    end else if (tick) begin
      if (home_cnt_q == 4'd9) begin
        home_cnt_d = '0;
        req_d[0]   = 1'b1;
      end else begin
        home_cnt_d = home_cnt_q + 4'd1;
      end
    end
`endif

    if (state_q == EMERGENCY) req_d = '0;

    // SOS overrides everything decided above, independent of tick phase.
    if (sos_rise) begin
      if (state_q == EMERGENCY) begin
        state_d = DOOR_OPEN;
        timer_d = T_LOAD;
      end else begin
        state_d = EMERGENCY;
        req_d   = '0;
        floor_d = floor_q;
        dir_d   = dir_q;
        timer_d = '0;
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      state_q    <= IDLE;
      floor_q    <= 3'b001;
      req_q      <= 3'b000;
      dir_q      <= 1'b1;
      timer_q    <= '0;
      sos_prev_q <= 1'b0;
      weight_q   <= 1'b0;
`ifdef ELEVATOR_HOME_RETURN_EN
      home_cnt_q <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      // Registered so clk is glitch-free; equals (cnt_q >= half period).
      clk_q      <= (cnt_d >= CNT_HALF);
      state_q    <= state_d;
      floor_q    <= floor_d;
      req_q      <= req_d;
      dir_q      <= dir_d;
      timer_q    <= timer_d;
      sos_prev_q <= sos_button;
      weight_q   <= weight_sensor;
`ifdef ELEVATOR_HOME_RETURN_EN
      home_cnt_q <= home_cnt_d;
`endif
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    clk             = clk_q;
    sos_led         = (state_q == EMERGENCY);
    weight_led      = weight_q;
    emergency_led   = (state_q == EMERGENCY) & clk_q;
    st_floor_led    = floor_q[0];
    nd_floor_led    = floor_q[1];
    rd_floor_led    = floor_q[2];
    door_status_led = (state_q == DOOR_OPEN) || (state_q == EMERGENCY);
  end

endmodule

// File: tb/tb_elevator_top.sv
module tb_elevator_top;
  localparam int CLKF = 100;

  logic CLK_50 = 1'b0;
  logic reset = 1'b1;
  logic clk, sos_button, weight_sensor;
  logic st_floor_button, nd_floor_button, rd_floor_button;
  logic sos_led, weight_led, emergency_led;
  logic st_floor_led, nd_floor_led, rd_floor_led, door_status_led;

  elevator_top #(.clk_frequency(CLKF), .DOOR_TICKS(3)) dut (
    .CLK_50(CLK_50), .reset(reset), .clk(clk),
    .sos_button(sos_button), .weight_sensor(weight_sensor),
    .st_floor_button(st_floor_button), .nd_floor_button(nd_floor_button),
    .rd_floor_button(rd_floor_button),
    .sos_led(sos_led), .weight_led(weight_led), .emergency_led(emergency_led),
    .st_floor_led(st_floor_led), .nd_floor_led(nd_floor_led),
    .rd_floor_led(rd_floor_led), .door_status_led(door_status_led)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    logic [2:0] btn;   // {rd, nd, st}
    logic       wt;
    logic       sos;
    int         ticks;
    logic [2:0] floor; // {rd, nd, st} LEDs
    logic       door;
    logic       sled;
    logic       wled;
    string      name;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [2:0] btn, input logic wt, input logic sos,
                              input int ticks, input logic [2:0] floor, input logic door,
                              input logic sled, input logic wled, input string name);
    vec_t v;
    v.btn = btn; v.wt = wt; v.sos = sos; v.ticks = ticks;
    v.floor = floor; v.door = door; v.sled = sled; v.wled = wled; v.name = name;
    return v;
  endfunction

  function automatic logic [5:0] obs();
    return {rd_floor_led, nd_floor_led, st_floor_led, door_status_led, sos_led, weight_led};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns just after the CLK_50 edge on which the divider ticked
  // (the falling edge of the divided clock).
  task automatic wait_tick();
    logic prev;
    bit   seen;
    prev = clk;
    seen = 0;
    for (int c = 0; c < 2 * CLKF && !seen; c++) begin
      @(posedge CLK_50); #1;
      if (prev === 1'b1 && clk === 1'b0) seen = 1;
      prev = clk;
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL tick_timeout: no divided-clock fall within %0d cycles", 2 * CLKF);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t s;
    @(negedge CLK_50);
    {rd_floor_button, nd_floor_button, st_floor_button} = v.btn;
    weight_sensor = v.wt;
    sos_button    = v.sos;
    s.exp  = {v.floor, v.door, v.sled, v.wled};
    s.name = v.name;
    sbq.push_back(s);
    @(negedge CLK_50);
    {rd_floor_button, nd_floor_button, st_floor_button} = 3'b000;
    sos_button = 1'b0;
    repeat (v.ticks) wait_tick();
    s = sbq.pop_front();
    check(s.name, {26'd0, obs()}, {26'd0, s.exp});
  endtask

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad, tog;
    logic prev;

    sos_button = 0; weight_sensor = 0;
    st_floor_button = 0; nd_floor_button = 0; rd_floor_button = 0;

    //            btn     wt    sos  tk floor   door  sos   wled
    vecs.push_back(mk(3'b100, 1'b0, 1'b0, 1, 3'b010, 1'b0, 1'b0, 1'b0, "rd_call_step2"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b100, 1'b0, 1'b0, 1'b0, "step3"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b100, 1'b1, 1'b0, 1'b0, "open_at3"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 2, 3'b100, 1'b1, 1'b0, 1'b0, "door_held3"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b100, 1'b0, 1'b0, 1'b0, "door_closed3"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 2, 3'b100, 1'b0, 1'b0, 1'b0, "reqs_cleared"));
    vecs.push_back(mk(3'b010, 1'b0, 1'b0, 1, 3'b010, 1'b0, 1'b0, 1'b0, "nd_call_down"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b010, 1'b1, 1'b0, 1'b0, "open_at2"));
    vecs.push_back(mk(3'b000, 1'b1, 1'b0, 0, 3'b010, 1'b1, 1'b0, 1'b1, "weight_led_on"));
    vecs.push_back(mk(3'b000, 1'b1, 1'b0, 10, 3'b010, 1'b1, 1'b0, 1'b1, "weight_holds_door"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 2, 3'b010, 1'b1, 1'b0, 1'b0, "unload_still_open"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b010, 1'b0, 1'b0, 1'b0, "unload_closed"));
    vecs.push_back(mk(3'b001, 1'b1, 1'b0, 2, 3'b010, 1'b0, 1'b0, 1'b1, "weight_blocks_depart"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b001, 1'b0, 1'b0, 1'b0, "depart_to1"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b001, 1'b1, 1'b0, 1'b0, "open_at1"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0, 1'b0, 1'b0, "close_at1"));
    vecs.push_back(mk(3'b100, 1'b0, 1'b0, 1, 3'b010, 1'b0, 1'b0, 1'b0, "up_again"));
    vecs.push_back(mk(3'b001, 1'b0, 1'b0, 1, 3'b100, 1'b0, 1'b0, 1'b0, "call1_keeps_up"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b100, 1'b1, 1'b0, 1'b0, "serve3_first"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 3, 3'b100, 1'b0, 1'b0, 1'b0, "close3_pending1"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b010, 1'b0, 1'b0, 1'b0, "return_down2"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b001, 1'b0, 1'b0, 1'b0, "return_down1"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b001, 1'b1, 1'b0, 1'b0, "serve1"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0, 1'b0, 1'b0, "close1_again"));
    vecs.push_back(mk(3'b001, 1'b0, 1'b0, 1, 3'b001, 1'b1, 1'b0, 1'b0, "call_here_opens"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 2, 3'b001, 1'b1, 1'b0, 1'b0, "door_timer_mid"));
    vecs.push_back(mk(3'b001, 1'b0, 1'b0, 2, 3'b001, 1'b1, 1'b0, 1'b0, "repress_reloads"));
    vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1, 3'b001, 1'b0, 1'b0, 1'b0, "reload_then_close"));

    // Reset state
    repeat (3) @(posedge CLK_50);
    #1;
    check("reset_state", {24'd0, clk, emergency_led, obs()}, {24'd0, 1'b0, 1'b0, 6'b001000});

    // Divider shape: after release, cycle k holds counter k mod CLKF
    @(negedge CLK_50);
    reset = 1'b0;
    bad = 0; tog = 0; prev = clk;
    for (int k = 1; k <= 5 * CLKF; k++) begin
      @(posedge CLK_50); #1;
      if (clk !== (((k % CLKF) >= CLKF / 2) ? 1'b1 : 1'b0)) bad++;
      if (clk !== prev) tog++;
      prev = clk;
    end
    check("div_shape_errors", bad, 0);
    check("div_toggles", tog, 10);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // SOS while moving at floor 2
    apply(mk(3'b100, 1'b0, 1'b0, 1, 3'b010, 1'b0, 1'b0, 1'b0, "sos_pre_move"));
    apply(mk(3'b000, 1'b0, 1'b1, 0, 3'b010, 1'b1, 1'b1, 1'b0, "sos_enter"));
    bad = 0; tog = 0; prev = emergency_led;
    for (int k = 0; k < 250; k++) begin
      @(posedge CLK_50); #1;
      if (emergency_led !== clk) bad++;
      if (emergency_led !== prev) tog++;
      prev = emergency_led;
    end
    check("sos_blink_follows_clk", bad, 0);
    check("sos_blink_toggles", (tog >= 4) ? 1 : 0, 1);
    apply(mk(3'b111, 1'b0, 1'b0, 3, 3'b010, 1'b1, 1'b1, 1'b0, "sos_ignores_buttons"));
    apply(mk(3'b000, 1'b0, 1'b1, 0, 3'b010, 1'b1, 1'b0, 1'b0, "sos_exit_door_open"));
    apply(mk(3'b000, 1'b0, 1'b0, 3, 3'b010, 1'b0, 1'b0, 1'b0, "sos_exit_closes"));
    apply(mk(3'b000, 1'b0, 1'b0, 2, 3'b010, 1'b0, 1'b0, 1'b0, "sos_requests_dropped"));

    // Reset mid-move at floor 3 with the divided clock high
    apply(mk(3'b100, 1'b0, 1'b0, 1, 3'b100, 1'b0, 1'b0, 1'b0, "move_to3"));
    repeat (60) @(negedge CLK_50);
    check("clk_high_before_reset", {31'd0, clk}, 32'd1);
    reset = 1'b1;
    @(negedge CLK_50);
    check("reset_mid_move", {24'd0, clk, emergency_led, obs()}, {24'd0, 1'b0, 1'b0, 6'b001000});
    reset = 1'b0;
    apply(mk(3'b000, 1'b0, 1'b0, 2, 3'b001, 1'b0, 1'b0, 1'b0, "post_reset_no_reqs"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
